// File: rtl/wb_unit.sv
// rtl/wb_unit.sv - miniRV writeback stage: source select, load extraction, register-file write port
module wb_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      in_rd,
   input  logic            in_rf_wen,
   input  logic [1:0]      in_wb_sel,
   input  logic [2:0]      in_funct3,
   input  logic [XLEN-1:0] in_alu_res,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_imm,
   input  logic            dram_rvalid,
   input  logic [XLEN-1:0] dram_rdata,
   output logic [4:0]      w_addr,
   output logic [XLEN-1:0] w_data,
   output logic            w_en,
   output logic            busy
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      WRITE    = 2'd2
   } state_t;

   localparam logic [1:0] SEL_ALU = 2'b00;
   localparam logic [1:0] SEL_MEM = 2'b01;
   localparam logic [1:0] SEL_PC4 = 2'b10;

   state_t          state;
   state_t          state_nxt;

   logic [4:0]      rd_q;
   logic            rf_wen_q;
   logic [2:0]      funct3_q;
   logic [1:0]      off_q;

   logic            xfer;
   logic            wr_direct;
   logic            wr_load;
   logic [XLEN-1:0] src_val;
   logic [XLEN-1:0] load_val;
   logic [7:0]      byte_sel;
   logic [15:0]     half_sel;

   // Blocked while a load is outstanding and while reset is held.
   assign in_ready  = !rst && (state != WAIT_MEM);
   assign xfer      = in_valid && in_ready;
   assign wr_direct = xfer && (in_wb_sel != SEL_MEM);
   assign wr_load   = (state == WAIT_MEM) && dram_rvalid;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: IDLE and WRITE share the accept rules so writes can run back-to-back.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (xfer) begin
               state_nxt = (in_wb_sel == SEL_MEM) ? WAIT_MEM : WRITE;
            end
         end
         WAIT_MEM: begin
            if (dram_rvalid) begin
               state_nxt = WRITE;
            end
         end
         WRITE: begin
            if (xfer) begin
               state_nxt = (in_wb_sel == SEL_MEM) ? WAIT_MEM : WRITE;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Non-load source mux; the load path is resolved later from the DRAM word.
   always_comb begin
      src_val = in_imm;
      case (in_wb_sel)
         SEL_ALU: src_val = in_alu_res;
         SEL_PC4: src_val = in_pc + 32'd4;
         default: src_val = in_imm;
      endcase
   end

   // Byte/halfword extraction and extension of the returned DRAM word.
   always_comb begin
      byte_sel = dram_rdata[7:0];
      case (off_q)
         2'd0: byte_sel = dram_rdata[7:0];
         2'd1: byte_sel = dram_rdata[15:8];
         2'd2: byte_sel = dram_rdata[23:16];
         2'd3: byte_sel = dram_rdata[31:24];
         default: byte_sel = dram_rdata[7:0];
      endcase
      half_sel = off_q[1] ? dram_rdata[31:16] : dram_rdata[15:0];
      load_val = dram_rdata;
      case (funct3_q)
         3'b000: load_val = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         3'b100: load_val = {{(XLEN-8){1'b0}}, byte_sel};
         3'b001: load_val = {{(XLEN-16){half_sel[15]}}, half_sel};
         3'b101: load_val = {{(XLEN-16){1'b0}}, half_sel};
         default: load_val = dram_rdata;
      endcase
   end

   // Instruction fields held across the memory wait.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q     <= 5'd0;
         rf_wen_q <= 1'b0;
         funct3_q <= 3'd0;
         off_q    <= 2'd0;
      end else if (xfer) begin
         rd_q     <= in_rd;
         rf_wen_q <= in_rf_wen;
         funct3_q <= in_funct3;
         off_q    <= in_alu_res[1:0];
      end
   end

   // Registered write port: loaded only on entry to WRITE, so address/data hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_en   <= 1'b0;
         w_addr <= 5'd0;
         w_data <= '0;
         busy   <= 1'b0;
      end else begin
         busy <= (state_nxt != IDLE);
         w_en <= 1'b0;
         if (wr_direct) begin
            w_addr <= in_rd;
            w_data <= src_val;
            w_en   <= in_rf_wen && (in_rd != 5'd0);
         end else if (wr_load) begin
            w_addr <= rd_q;
            w_data <= load_val;
            w_en   <= rf_wen_q && (rd_q != 5'd0);
         end
      end
   end

endmodule
